// File: rtl/rnn_host_loader.sv
// Bus master that streams an RNN parameter image into the rnn accelerator,
// starts it, polls for completion and reads back the hidden vector.
module rnn_host_loader #(
  parameter int unsigned IN_DIM   = 2,
  parameter int unsigned HID_DIM  = 4,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MEM_AW   = 8,
  parameter int unsigned POLL_MAX = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [MEM_AW-1:0] mem_base,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_rd,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              write,
  output logic              read,
  output logic [31:0]       addr,
  output logic [31:0]       data_out,
  input  logic [31:0]       data_in,
  output logic              h_valid,
  output logic [7:0]        h_idx,
  output logic [DATA_W-1:0] h_data
);

  localparam int unsigned PCW = $clog2(POLL_MAX + 1);

  typedef enum logic [3:0] {
    StIdle, StFetch, StWr, StStart, StPollRq, StPollWt, StRdRq, StRdWt, StFin
  } state_e;

  state_e            state_q;
  logic [MEM_AW-1:0] ptr_q;
  logic [1:0]        sec_q;   // 0 embed, 1 W, 2 U, 3 bias
  logic [7:0]        row_q;
  logic [7:0]        col_q;
  logic [PCW-1:0]    poll_q;
  logic [7:0]        hidx_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic [7:0]  rows_m1;
  logic [7:0]  cols_m1;
  logic        last_elem;
  logic [15:0] val16;

  // Upper read-data bits carry nothing this master needs.
  logic unused_din;
  assign unused_din = ^data_in[31:DATA_W];

  always_comb begin
    rows_m1 = 8'd0;
    cols_m1 = 8'(HID_DIM - 1);
    unique case (sec_q)
      2'd0: cols_m1 = 8'(IN_DIM - 1);
      2'd1: rows_m1 = 8'(IN_DIM - 1);
      2'd2: rows_m1 = 8'(HID_DIM - 1);
      2'd3: rows_m1 = 8'd0;
    endcase
  end

  assign last_elem = (sec_q == 2'd3) && (col_q == cols_m1);
  assign val16     = 16'($signed(mem_rdata));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      sec_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      poll_q  <= '0;
      hidx_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (go) begin
            state_q <= StFetch;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            ptr_q   <= mem_base;
            sec_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            poll_q  <= '0;
            hidx_q  <= '0;
          end
        end
        StFetch: state_q <= StWr;
        StWr: begin
          ptr_q <= ptr_q + MEM_AW'(1);
          if (col_q == cols_m1) begin
            col_q <= '0;
            if (row_q == rows_m1) begin
              row_q <= '0;
              sec_q <= sec_q + 2'd1;
            end else begin
              row_q <= row_q + 8'd1;
            end
          end else begin
            col_q <= col_q + 8'd1;
          end
          state_q <= last_elem ? StStart : StFetch;
        end
        StStart:  state_q <= StPollRq;
        StPollRq: state_q <= StPollWt;
        StPollWt: begin
          if (data_in[0]) begin
            state_q <= StRdRq;
            hidx_q  <= '0;
          end else if (poll_q == PCW'(POLL_MAX - 1)) begin
            state_q <= StFin;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            poll_q  <= poll_q + PCW'(1);
            state_q <= StPollRq;
          end
        end
        StRdRq: state_q <= StRdWt;
        StRdWt: begin
          if (hidx_q == 8'(HID_DIM - 1)) begin
            state_q <= StFin;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            hidx_q  <= hidx_q + 8'd1;
            state_q <= StRdRq;
          end
        end
        StFin:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Bus outputs follow the state directly; write data needs mem_rdata in the WR cycle.
  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = '0;
    write    = 1'b0;
    read     = 1'b0;
    addr     = '0;
    data_out = '0;
    h_valid  = 1'b0;
    h_idx    = '0;
    h_data   = '0;
    case (state_q)
      StFetch: begin
        mem_rd   = 1'b1;
        mem_addr = ptr_q;
      end
      StWr: begin
        write = 1'b1;
        unique case (sec_q)
          2'd0: begin addr = 32'd1; data_out = {8'h00, col_q, val16}; end
          2'd1: begin addr = 32'd2; data_out = {row_q, col_q, val16}; end
          2'd2: begin addr = 32'd3; data_out = {row_q, col_q, val16}; end
          2'd3: begin addr = 32'd4; data_out = {8'h00, col_q, val16}; end
        endcase
      end
      StStart:  write = 1'b1;
      StPollRq: read  = 1'b1;
      StRdRq: begin
        read = 1'b1;
        addr = 32'd8 + 32'(hidx_q);
      end
      StRdWt: begin
        h_valid = 1'b1;
        h_idx   = hidx_q;
        h_data  = data_in[DATA_W-1:0];
      end
      default: ;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_rnn_host_loader.sv
// Directed bench for rnn_host_loader: parameter memory model, rnn slave stub,
// bus monitor and one task per scenario.
module tb_rnn_host_loader;

  localparam int unsigned IN_DIM   = 2;
  localparam int unsigned HID_DIM  = 4;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned MEM_AW   = 8;
  localparam int unsigned POLL_MAX = 8;
  localparam int LOG = 1024;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              go = 1'b0;
  logic [MEM_AW-1:0] mem_base = '0;
  logic              busy, done, err, mem_rd, write, read, h_valid;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [31:0]       addr, data_out;
  logic [31:0]       data_in = '0;
  logic [7:0]        h_idx;
  logic [DATA_W-1:0] h_data;

  rnn_host_loader #(
    .IN_DIM(IN_DIM), .HID_DIM(HID_DIM), .DATA_W(DATA_W), .MEM_AW(MEM_AW), .POLL_MAX(POLL_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .mem_base(mem_base), .busy(busy), .done(done),
    .err(err), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .write(write),
    .read(read), .addr(addr), .data_out(data_out), .data_in(data_in), .h_valid(h_valid),
    .h_idx(h_idx), .h_data(h_data)
  );

  always #5 clk = ~clk;

  wire [102:0] all_outs = {busy, done, err, mem_rd, mem_addr, write, read, addr, data_out,
                           h_valid, h_idx, h_data};

  int n_cmp = 0;
  int n_fail = 0;

  // Parameter memory: one-cycle read latency.
  logic [15:0] mem [256];
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  // Monitor logs, monotonic; tests take snapshots before each run.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] wr_addr [LOG];
  logic [31:0] wr_data [LOG];
  int          wr_cyc [LOG];
  logic [7:0]  fetch_addr [LOG];
  logic [15:0] h_data_log [LOG];
  logic [7:0]  h_idx_log [LOG];
  int wr_total = 0, poll_total = 0, fetch_total = 0, h_total = 0, done_total = 0;
  int conflict_total = 0;
  logic err_at_done = 1'b0;

  always @(negedge clk) begin
    if (write) begin
      if (wr_total < LOG) begin
        wr_addr[wr_total] = addr; wr_data[wr_total] = data_out; wr_cyc[wr_total] = cyc;
      end
      wr_total++;
    end
    if (read && addr == 32'd0) poll_total++;
    if (read && write) conflict_total++;
    if (mem_rd) begin
      if (fetch_total < LOG) fetch_addr[fetch_total] = mem_addr;
      fetch_total++;
    end
    if (h_valid) begin
      if (h_total < LOG) begin h_data_log[h_total] = h_data; h_idx_log[h_total] = h_idx; end
      h_total++;
    end
    if (done) begin done_total++; err_at_done = err; end
  end

  // rnn slave stub: status goes ready once poll_total passes ready_thresh.
  int ready_thresh = 32'h7fffffff;
  logic [15:0] hid_vals [4];
  always @(posedge clk) begin
    if (read) begin
      if (addr == 32'd0) data_in <= {31'b0, (poll_total > ready_thresh)};
      else data_in <= {{16{hid_vals[addr[1:0]][15]}}, hid_vals[addr[1:0]]};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
    $fatal(1);
  end

  task automatic load_image(input logic [7:0] base);
    logic [15:0] img [30];
    img[0] = 16'd2;  img[1] = -16'sd3;
    img[2] = 16'd2;  img[3] = -16'sd10; img[4] = -16'sd10; img[5] = 16'd3;
    img[6] = 16'd6;  img[7] = 16'd9;    img[8] = 16'd12;   img[9] = 16'd1;
    for (int k = 0; k < 16; k++) img[10+k] = 16'(100 + k);
    img[26] = -16'sd2; img[27] = -16'sd2; img[28] = -16'sd1; img[29] = -16'sd1;
    for (int k = 0; k < 30; k++) mem[8'(int'(base) + k)] = img[k];
  endtask

  task automatic pulse_go(input logic [7:0] base);
    @(negedge clk); mem_base = base; go = 1'b1;
    @(negedge clk); go = 1'b0;
  endtask

  task automatic wait_done(input int db, input string name);
    for (int k = 0; k < 2000 && done_total == db; k++) begin @(negedge clk); #1; end
    n_cmp++;
    if (done_total == db) begin
      n_fail++; $display("FAIL %s_timeout: done count %0d, required > %0d", name, done_total, db);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; go = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL reset_outs: got %h, required 0", all_outs);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL idle_outs: got %h, required 0", all_outs);
    end
  endtask

  task automatic test_load_readback;
    int wb, pb, hb, db, fb, bad;
    logic [63:0] exp_wr [11];
    int exp_ix [11];
    logic [15:0] exp_h [4];
    exp_ix[0] = 0;   exp_wr[0] = {32'd1, 32'h0000_0002};
    exp_ix[1] = 1;   exp_wr[1] = {32'd1, 32'h0001_FFFD};
    exp_ix[2] = 2;   exp_wr[2] = {32'd2, 32'h0000_0002};
    exp_ix[3] = 3;   exp_wr[3] = {32'd2, 32'h0001_FFF6};
    exp_ix[4] = 6;   exp_wr[4] = {32'd2, 32'h0100_0006};
    exp_ix[5] = 9;   exp_wr[5] = {32'd2, 32'h0103_0001};
    exp_ix[6] = 10;  exp_wr[6] = {32'd3, 32'h0000_0064};
    exp_ix[7] = 15;  exp_wr[7] = {32'd3, 32'h0101_0069};
    exp_ix[8] = 25;  exp_wr[8] = {32'd3, 32'h0303_0073};
    exp_ix[9] = 26;  exp_wr[9] = {32'd4, 32'h0000_FFFE};
    exp_ix[10] = 29; exp_wr[10] = {32'd4, 32'h0003_FFFF};
    exp_h[0] = 16'hFFF0; exp_h[1] = 16'hFFCF; exp_h[2] = 16'hFFC7; exp_h[3] = 16'h0002;
    for (int k = 0; k < 4; k++) hid_vals[k] = exp_h[k];
    wb = wr_total; pb = poll_total; hb = h_total; db = done_total; fb = fetch_total;
    ready_thresh = poll_total + 3;
    load_image(8'h10);
    pulse_go(8'h10);
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL load_busy: got %b, required 1", busy); end
    wait_done(db, "load");
    repeat (3) @(negedge clk);
    n_cmp++;
    if (wr_total - wb != 31) begin
      n_fail++; $display("FAIL load_write_count: got %0d, required 31", wr_total - wb);
    end
    n_cmp++;
    if (fetch_addr[fb] !== 8'h10) begin
      n_fail++; $display("FAIL load_first_fetch: got %h, required 10", fetch_addr[fb]);
    end
    for (int k = 0; k < 11; k++) begin
      n_cmp++;
      if ({wr_addr[wb+exp_ix[k]], wr_data[wb+exp_ix[k]]} !== exp_wr[k]) begin
        n_fail++;
        $display("FAIL load_write_%0d: got addr %h data %h, required %h", exp_ix[k],
                 wr_addr[wb+exp_ix[k]], wr_data[wb+exp_ix[k]], exp_wr[k]);
      end
    end
    n_cmp++;
    if ({wr_addr[wb+30], wr_data[wb+30]} !== 64'd0) begin
      n_fail++; $display("FAIL start_write: got addr %h data %h, required 0/0",
                         wr_addr[wb+30], wr_data[wb+30]);
    end
    bad = 0;
    for (int k = 1; k < 30; k++) if (wr_cyc[wb+k] - wr_cyc[wb+k-1] != 2) bad++;
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL write_spacing: %0d gaps not 2, required 0", bad); end
    n_cmp++;
    if (poll_total - pb != 4) begin
      n_fail++; $display("FAIL poll_count: got %0d, required 4", poll_total - pb);
    end
    n_cmp++;
    if (h_total - hb != 4) begin
      n_fail++; $display("FAIL h_count: got %0d, required 4", h_total - hb);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({h_idx_log[hb+k], h_data_log[hb+k]} !== {8'(k), exp_h[k]}) begin
        n_fail++; $display("FAIL h_elem_%0d: got idx %0d data %h, required idx %0d data %h", k,
                           h_idx_log[hb+k], h_data_log[hb+k], k, exp_h[k]);
      end
    end
    n_cmp++;
    if (done_total - db != 1 || err_at_done !== 1'b0) begin
      n_fail++; $display("FAIL load_done: got %0d dones err %b, required 1 dones err 0",
                         done_total - db, err_at_done);
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL load_idle_busy: got %b, required 0", busy); end
  endtask

  task automatic test_timeout;
    int pb, hb, db;
    ready_thresh = 32'h7fffffff;
    pb = poll_total; hb = h_total; db = done_total;
    pulse_go(8'h10);
    wait_done(db, "timeout");
    n_cmp++;
    if (poll_total - pb != 8) begin
      n_fail++; $display("FAIL timeout_polls: got %0d, required 8", poll_total - pb);
    end
    n_cmp++;
    if (err_at_done !== 1'b1) begin
      n_fail++; $display("FAIL timeout_err_at_done: got %b, required 1", err_at_done);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (h_total != hb) begin
      n_fail++; $display("FAIL timeout_h_valid: got %0d, required 0", h_total - hb);
    end
    n_cmp++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL err_held: got %b, required 1", err); end
    ready_thresh = poll_total;
    db = done_total;
    pulse_go(8'h10);
    n_cmp++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b, required 0", err); end
    wait_done(db, "after_timeout");
    n_cmp++;
    if (err_at_done !== 1'b0) begin
      n_fail++; $display("FAIL after_timeout_err: got %b, required 0", err_at_done);
    end
  endtask

  task automatic test_reset_mid_load;
    int wb, db, wb2, fb;
    bit hit;
    ready_thresh = poll_total;
    wb = wr_total; db = done_total;
    pulse_go(8'h10);
    hit = 0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge clk); #1;
      if (wr_total - wb == 10) hit = 1;
    end
    n_cmp++;
    if (!hit) begin n_fail++; $display("FAIL rst_reach_write10: got %0d, required 10", wr_total - wb); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL rst_mid_outs: got %h, required 0", all_outs);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (50) @(negedge clk);
    n_cmp++;
    if (done_total != db || wr_total - wb != 10) begin
      n_fail++; $display("FAIL rst_no_done: got %0d dones %0d writes, required 0 dones 10 writes",
                         done_total - db, wr_total - wb);
    end
    wb2 = wr_total; fb = fetch_total;
    pulse_go(8'h10);
    wait_done(db, "restart");
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({wr_addr[wb2], wr_data[wb2]} !== {32'd1, 32'h0000_0002} || fetch_addr[fb] !== 8'h10) begin
      n_fail++; $display("FAIL restart_first: got addr %h data %h fetch %h, required 1/2/10",
                         wr_addr[wb2], wr_data[wb2], fetch_addr[fb]);
    end
    n_cmp++;
    if (wr_total - wb2 != 31) begin
      n_fail++; $display("FAIL restart_writes: got %0d, required 31", wr_total - wb2);
    end
  endtask

  task automatic test_go_spam;
    int wb, db;
    bit seen;
    ready_thresh = poll_total + 1;
    wb = wr_total; db = done_total;
    @(negedge clk); mem_base = 8'h10; go = 1'b1;
    seen = 0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge clk); #1;
      if (done) seen = 1;
    end
    @(posedge clk); #1; go = 1'b0;
    repeat (80) @(negedge clk);
    n_cmp++;
    if (!seen || done_total - db != 1) begin
      n_fail++; $display("FAIL spam_done: got %0d dones, required 1", done_total - db);
    end
    n_cmp++;
    if (wr_total - wb != 31 || busy !== 1'b0) begin
      n_fail++; $display("FAIL spam_writes: got %0d writes busy %b, required 31 busy 0",
                         wr_total - wb, busy);
    end
  endtask

  task automatic test_wrap;
    int wb, db, fb;
    ready_thresh = poll_total;
    for (int k = 0; k < 30; k++) mem[8'(240 + k)] = 16'(16'h1000 + k);
    mem[8'hFF] = 16'hABCD;
    mem[8'h00] = 16'h1234;
    wb = wr_total; db = done_total; fb = fetch_total;
    pulse_go(8'hF0);
    wait_done(db, "wrap");
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({fetch_addr[fb+15], fetch_addr[fb+16], fetch_addr[fb+29]} !== 24'hFF_00_0D) begin
      n_fail++; $display("FAIL wrap_fetch: got %h %h %h, required ff 00 0d",
                         fetch_addr[fb+15], fetch_addr[fb+16], fetch_addr[fb+29]);
    end
    n_cmp++;
    if ({wr_addr[wb], wr_data[wb]} !== {32'd1, 32'h0000_1000}) begin
      n_fail++; $display("FAIL wrap_first: got %h %h, required 1 00001000", wr_addr[wb], wr_data[wb]);
    end
    n_cmp++;
    if ({wr_addr[wb+15], wr_data[wb+15]} !== {32'd3, 32'h0101_ABCD}) begin
      n_fail++; $display("FAIL wrap_ff: got %h %h, required 3 0101abcd", wr_addr[wb+15], wr_data[wb+15]);
    end
    n_cmp++;
    if ({wr_addr[wb+16], wr_data[wb+16]} !== {32'd3, 32'h0102_1234}) begin
      n_fail++; $display("FAIL wrap_00: got %h %h, required 3 01021234", wr_addr[wb+16], wr_data[wb+16]);
    end
  endtask

  initial begin
    test_reset();
    test_load_readback();
    test_timeout();
    test_reset_mid_load();
    test_go_spam();
    test_wrap();
    n_cmp++;
    if (conflict_total != 0) begin
      n_fail++; $display("FAIL strobe_conflict: got %0d cycles, required 0", conflict_total);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
